// File: rtl/comm_link_rx_assembler.sv
// rtl/comm_link_rx_assembler.sv - comm link receive beat-pair assembler with word FIFO and credit token return
//
// Purpose:
//   Pairs consecutive 2-channel link beats into one core word.
//   The first beat lands in bits [2*CH_WIDTH-1:0] and the second beat in the upper half.
//   Completed words are buffered in a FIFO_DEPTH-entry receive FIFO.
//   The core drains the FIFO through a valid/yumi handshake.
//   Every TOKEN_RATIO words the core consumes, one credit is returned to the transmitter
//   by toggling io_token_o.
//
// Ports:
//   clk            link-side clock, all state on posedge
//   rst            synchronous active-high reset
//   io_valid_i     one beat present this cycle
//   io_data_ch0_i  channel 0 beat data (low half of the beat)
//   io_data_ch1_i  channel 1 beat data (high half of the beat)
//   core_data_o    FIFO head word
//   core_valid_o   FIFO non-empty
//   core_yumi_i    core consumes the head word this cycle
//   io_token_o     credit-return token level
//   count_o        words currently buffered
//   overflow_o     sticky: a completed word was dropped because the FIFO was full

module comm_link_rx_assembler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TOKEN_RATIO = 4,
    parameter int CH_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_valid_i,
    input  logic [CH_WIDTH-1:0]           io_data_ch0_i,
    input  logic [CH_WIDTH-1:0]           io_data_ch1_i,
    output logic [4*CH_WIDTH-1:0]         core_data_o,
    output logic                          core_valid_o,
    input  logic                          core_yumi_i,
    output logic                          io_token_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = 2 * CH_WIDTH;
    localparam int WW = 4 * CH_WIDTH;
    // A ratio of 1 would give a zero-width counter; keep one bit and let it sit at 0.
    localparam int TW = (TOKEN_RATIO > 1) ? $clog2(TOKEN_RATIO) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TOK_LAST = TW'(TOKEN_RATIO - 1);

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } asm_state_t;

    asm_state_t     state_r;
    logic [BW-1:0]  lo_r;
    logic [WW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [TW-1:0]  tok_cnt_r;
    logic           token_r;
    logic           overflow_r;

    logic           pop;
    logic           word_done;
    logic           push;
    logic [WW-1:0]  word;

    // Empty/full come from the occupancy count.
    // Pointer equality is ambiguous once the pointers wrap.
    assign core_valid_o = (count_r != '0);
    assign pop          = core_yumi_i && core_valid_o;
    assign word_done    = (state_r == ST_ODD) && io_valid_i;
    assign word         = {io_data_ch1_i, io_data_ch0_i, lo_r};
    // When full, a same-cycle pop frees the slot the new word needs.
    assign push         = word_done && ((count_r < DEPTH_C) || pop);

    assign core_data_o  = mem[rd_ptr_r];
    assign count_o      = count_r;
    assign io_token_o   = token_r;
    assign overflow_o   = overflow_r;

    // Beat pairing, FIFO bookkeeping and credit return.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_EVEN;
            lo_r       <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            tok_cnt_r  <= '0;
            token_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            // Idle cycles hold both the state and the stored first beat.
            if (io_valid_i) begin
                case (state_r)
                    ST_EVEN: begin
                        lo_r    <= {io_data_ch1_i, io_data_ch0_i};
                        state_r <= ST_ODD;
                    end
                    default: begin
                        state_r <= ST_EVEN;
                    end
                endcase
            end

            if (word_done && !push) begin
                overflow_r <= 1'b1;
            end

            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end

            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                if (tok_cnt_r == TOK_LAST) begin
                    tok_cnt_r <= '0;
                    token_r   <= ~token_r;
                end else begin
                    tok_cnt_r <= tok_cnt_r + TW'(1);
                end
            end

            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array has no reset.
    // The contents are never observed while count is zero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_r] <= word;
        end
    end

endmodule

// File: tb/tb_comm_link_rx_assembler.sv
// tb/tb_comm_link_rx_assembler.sv - self-checking bench for comm_link_rx_assembler

module tb_comm_link_rx_assembler;

    localparam int DEPTH = 8;
    localparam int RATIO = 4;
    localparam int CH    = 16;

    logic          clk;
    logic          rst;
    logic          io_valid_i;
    logic [CH-1:0] io_data_ch0_i;
    logic [CH-1:0] io_data_ch1_i;
    logic [63:0]   core_data_o;
    logic          core_valid_o;
    logic          core_yumi_i;
    logic          io_token_o;
    logic [3:0]    count_o;
    logic          overflow_o;

    int total = 0;
    int bad   = 0;

    // Reference model: a word queue plus a half-word holder and a token level.
    logic [63:0] mq[$];
    bit          m_half;
    logic [31:0] m_lo;
    int          m_tokcnt;
    bit          m_tok;
    bit          m_ovf;

    comm_link_rx_assembler #(
        .FIFO_DEPTH (DEPTH),
        .TOKEN_RATIO(RATIO),
        .CH_WIDTH   (CH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io_valid_i   (io_valid_i),
        .io_data_ch0_i(io_data_ch0_i),
        .io_data_ch1_i(io_data_ch1_i),
        .core_data_o  (core_data_o),
        .core_valid_o (core_valid_o),
        .core_yumi_i  (core_yumi_i),
        .io_token_o   (io_token_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one reset cycle and clear the model.
    task automatic do_reset();
        rst = 1'b1;
        io_valid_i = 1'b0;
        core_yumi_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_half = 0;
        m_lo = '0;
        m_tokcnt = 0;
        m_tok = 0;
        m_ovf = 0;
    endtask

    // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
    task automatic cycle(input bit v, input logic [CH-1:0] c1, input logic [CH-1:0] c0, input bit y);
        bit pop;
        io_valid_i = v;
        io_data_ch1_i = c1;
        io_data_ch0_i = c0;
        core_yumi_i = y;
        pop = y && (mq.size() > 0);
        if (pop) begin
            void'(mq.pop_front());
            m_tokcnt++;
            if (m_tokcnt == RATIO) begin
                m_tokcnt = 0;
                m_tok = ~m_tok;
            end
        end
        if (v) begin
            if (!m_half) begin
                m_lo = {c1, c0};
                m_half = 1;
            end else begin
                m_half = 0;
                if (mq.size() < DEPTH) mq.push_back({c1, c0, m_lo});
                else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        io_valid_i = 1'b0;
        core_yumi_i = 1'b0;
    endtask

    // Send one complete word as two back-to-back beats, with no pop.
    task automatic send_word(input logic [63:0] w);
        cycle(1, w[31:16], w[15:0], 0);
        cycle(1, w[63:48], w[47:32], 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io_valid_i = 1'b1;
        io_data_ch0_i = 16'hdead;
        io_data_ch1_i = 16'hbeef;
        core_yumi_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", core_valid_o); end
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL reset_token got=%0b exp=0", io_token_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow_o); end
        do_reset();
    endtask

    task automatic test_single_word();
        do_reset();
        cycle(1, 16'h1111, 16'h2222, 0);
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL single_half_valid got=%0b exp=0", core_valid_o); end
        cycle(1, 16'h3333, 16'h4444, 0);
        total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", core_valid_o); end
        total++; if (core_data_o !== 64'h3333_4444_1111_2222) begin bad++; $display("FAIL single_data got=%h exp=%h", core_data_o, 64'h3333_4444_1111_2222); end
        total++; if (count_o !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count_o); end
        cycle(0, 0, 0, 1);
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0b exp=0", core_valid_o); end
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_gapped();
        do_reset();
        cycle(1, 16'hAAAA, 16'hBBBB, 0);
        repeat (5) cycle(0, 16'h5555, 16'h6666, 0);
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL gap_midcount got=%0d exp=0", count_o); end
        cycle(1, 16'hCCCC, 16'hDDDD, 0);
        total++; if (count_o !== 4'd1) begin bad++; $display("FAIL gap_count got=%0d exp=1", count_o); end
        total++; if (core_data_o !== 64'hCCCC_DDDD_AAAA_BBBB) begin bad++; $display("FAIL gap_data got=%h exp=%h", core_data_o, 64'hCCCC_DDDD_AAAA_BBBB); end
        cycle(0, 0, 0, 1);
        send_word(64'h0123_4567_89AB_CDEF);
        total++; if (count_o !== 4'd1) begin bad++; $display("FAIL gap_even_count got=%0d exp=1", count_o); end
        total++; if (core_data_o !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL gap_even_data got=%h exp=%h", core_data_o, 64'h0123_4567_89AB_CDEF); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_word(64'(i));
        total++; if (count_o !== 4'd8) begin bad++; $display("FAIL ovf_fullcount got=%0d exp=8", count_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", overflow_o); end
        send_word(64'd8);
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", overflow_o); end
        total++; if (count_o !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count_o); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (core_data_o !== 64'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, core_data_o, 64'(i)); end
            cycle(0, 0, 0, 1);
        end
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL ovf_empty got=%0d exp=0", count_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow_o); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_word(64'h10 + 64'(i));
        cycle(1, 16'h0000, 16'h0018, 0);
        cycle(1, 16'h0000, 16'h0000, 1);
        total++; if (count_o !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", count_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%0b exp=0", overflow_o); end
        for (int i = 1; i <= DEPTH; i++) begin
            total++; if (core_data_o !== 64'h10 + 64'(i)) begin bad++; $display("FAIL fpp_order%0d got=%h exp=%h", i, core_data_o, 64'h10 + 64'(i)); end
            cycle(0, 0, 0, 1);
        end
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%0b exp=0", core_valid_o); end
    endtask

    task automatic test_token();
        bit exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_word(64'h100 + 64'(i));
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(0, 0, 0, 1);
            exp = (k >= RATIO && k < 2 * RATIO);
            total++; if (io_token_o !== exp) begin bad++; $display("FAIL token_pop%0d got=%0b exp=%0b", k, io_token_o, exp); end
            if (k == RATIO - 1) begin
                repeat (3) cycle(0, 0, 0, 0);
                total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL token_idle got=%0b exp=0", io_token_o); end
            end
        end
    endtask

    task automatic test_yumi_empty();
        do_reset();
        repeat (3) cycle(0, 0, 0, 1);
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL yempty_count got=%0d exp=0", count_o); end
        for (int i = 0; i < RATIO - 1; i++) begin
            send_word(64'h200 + 64'(i));
            cycle(0, 0, 0, 1);
        end
        total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL yempty_token3 got=%0b exp=0", io_token_o); end
        send_word(64'h2FF);
        cycle(0, 0, 0, 1);
        total++; if (io_token_o !== 1'b1) begin bad++; $display("FAIL yempty_token4 got=%0b exp=1", io_token_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_word(64'h1);
        send_word(64'h2);
        for (int i = 0; i < RATIO - 1; i++) cycle(0, 0, 0, 1);
        cycle(1, 16'h9999, 16'h8888, 0);
        do_reset();
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL mrst_count got=%0d exp=0", count_o); end
        total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL mrst_token got=%0b exp=0", io_token_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL mrst_ovf got=%0b exp=0", overflow_o); end
        cycle(1, 16'hA1A1, 16'hA0A0, 0);
        cycle(1, 16'hB1B1, 16'hB0B0, 0);
        total++; if (count_o !== 4'd1) begin bad++; $display("FAIL mrst_wcount got=%0d exp=1", count_o); end
        total++; if (core_data_o !== 64'hB1B1_B0B0_A1A1_A0A0) begin bad++; $display("FAIL mrst_word got=%h exp=%h", core_data_o, 64'hB1B1_B0B0_A1A1_A0A0); end
        // Popping the only word must not complete a token group with pre-reset pops.
        cycle(0, 0, 0, 1);
        total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL mrst_tokcnt got=%0b exp=0", io_token_o); end
    endtask

    task automatic test_random();
        bit v;
        bit y;
        int ypct;
        int errs;
        errs = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            // Alternate phases so the FIFO both fills to overflow and drains dry.
            ypct = ((n / 300) % 2 == 0) ? 15 : 70;
            v = ($urandom_range(99) < 60);
            y = (mq.size() > 0) && ($urandom_range(99) < ypct);
            cycle(v, 16'($urandom), 16'($urandom), y);
            total++;
            if (core_valid_o !== (mq.size() > 0) || count_o !== 4'(mq.size()) ||
                io_token_o !== m_tok || overflow_o !== m_ovf ||
                (mq.size() > 0 && core_data_o !== mq[0])) begin
                bad++;
                if (errs < 10) begin
                    $display("FAIL rand_c%0d got v=%0b n=%0d t=%0b o=%0b d=%h exp v=%0b n=%0d t=%0b o=%0b d=%h",
                             n, core_valid_o, count_o, io_token_o, overflow_o, core_data_o,
                             mq.size() > 0, mq.size(), m_tok, m_ovf, (mq.size() > 0) ? mq[0] : 64'h0);
                end
                errs++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        io_valid_i = 1'b0;
        io_data_ch0_i = '0;
        io_data_ch1_i = '0;
        core_yumi_i = 1'b0;
        test_reset();
        test_single_word();
        test_gapped();
        test_overflow();
        test_full_push_pop();
        test_token();
        test_yumi_empty();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
